// File: rtl/bch_pkg.sv
// Shared constants, FSM state type and GF(2^10) helpers for the BCH syndrome block.
package bch_pkg;

    localparam int unsigned M           = 10;
    localparam int unsigned N           = 542;
    localparam int unsigned K           = 512;
    localparam int unsigned FIELD_ORDER = 1023;
    localparam logic [M-1:0] PRIM_POLY  = 10'h009;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    // Multiply by alpha: shift up and fold x^10 back as x^3 + 1.
    function automatic logic [M-1:0] gf_mul_alpha(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY : {M{1'b0}});
    endfunction

    // alpha^e in polynomial basis; used to build constant XOR networks.
    function automatic logic [M-1:0] alpha_pow(input int unsigned e);
        logic [M-1:0] v;
        v = {{(M-1){1'b0}}, 1'b1};
        for (int unsigned i = 0; i < e % FIELD_ORDER; i++) begin
            v = gf_mul_alpha(v);
        end
        return v;
    endfunction

    // Squaring is linear over GF(2): bit i of the input maps to alpha^(2i).
    function automatic logic [M-1:0] gf_square(input logic [M-1:0] a);
        logic [M-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (a[i]) r = r ^ alpha_pow(2 * i);
        end
        return r;
    endfunction

endpackage

// File: rtl/bch_syn_chunk.sv
// One Horner step for syndrome S_J: acc_out = acc_in * alpha^(J*CHUNK) + sum chunk[b]*alpha^(J*b).
module bch_syn_chunk
    import bch_pkg::*;
#(
    parameter int unsigned J     = 1,
    parameter int unsigned CHUNK = 64
) (
    input  logic [M-1:0]     acc_in,
    input  logic [CHUNK-1:0] chunk,
    output logic [M-1:0]     acc_out
);

    // Column i of the constant multiplier: alpha^i * alpha^(J*CHUNK).
    function automatic logic [M*M-1:0] build_shift_tab();
        logic [M*M-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < M; i++) begin
            t[i*M +: M] = alpha_pow(J * CHUNK + i);
        end
        return t;
    endfunction

    // Contribution of each received bit within the chunk: alpha^(J*b).
    function automatic logic [CHUNK*M-1:0] build_bit_tab();
        logic [CHUNK*M-1:0] t;
        t = '0;
        for (int unsigned b = 0; b < CHUNK; b++) begin
            t[b*M +: M] = alpha_pow(J * b);
        end
        return t;
    endfunction

    localparam logic [M*M-1:0]     SHIFT_TAB = build_shift_tab();
    localparam logic [CHUNK*M-1:0] BIT_TAB   = build_bit_tab();

    // Fixed XOR network: scale the accumulator, then fold in the chunk bits.
    always_comb begin
        acc_out = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (acc_in[i]) acc_out = acc_out ^ SHIFT_TAB[i*M +: M];
        end
        for (int unsigned b = 0; b < CHUNK; b++) begin
            if (chunk[b]) acc_out = acc_out ^ BIT_TAB[b*M +: M];
        end
    end

endmodule

// File: rtl/bch_syndrome_seq.sv
// Iterative syndrome generator for the (542,512) triple-error BCH code over GF(2^10).
module bch_syndrome_seq
    import bch_pkg::*;
#(
    parameter int unsigned CHUNK = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] received,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] received_out,
    output logic [M-1:0] syndrome1,
    output logic [M-1:0] syndrome2,
    output logic [M-1:0] syndrome3,
    output logic [M-1:0] syndrome4,
    output logic [M-1:0] syndrome5,
    output logic         no_error
);

    localparam int unsigned NCHUNK = (N + CHUNK - 1) / CHUNK;
    localparam int unsigned W      = NCHUNK * CHUNK;
    localparam int unsigned CNT_W  = $clog2(NCHUNK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     word_q;
    logic [CNT_W-1:0] cnt_q;
    logic [M-1:0]     a1_q, a3_q, a5_q;
    logic [M-1:0]     a1_d, a3_d, a5_d;
    logic [CHUNK-1:0] chunk;
    logic [M-1:0]     a1_sq;
    logic             accept;

    // Highest chunk first so Horner's rule ends on the x^0 coefficients.
    assign chunk = word_q[cnt_q*CHUNK +: CHUNK];

    bch_syn_chunk #(.J(1), .CHUNK(CHUNK)) u_syn1 (.acc_in(a1_q), .chunk(chunk), .acc_out(a1_d));
    bch_syn_chunk #(.J(3), .CHUNK(CHUNK)) u_syn3 (.acc_in(a3_q), .chunk(chunk), .acc_out(a3_d));
    bch_syn_chunk #(.J(5), .CHUNK(CHUNK)) u_syn5 (.acc_in(a5_q), .chunk(chunk), .acc_out(a5_d));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state and handshake decode; no accept while a result is pending.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Word register, chunk counter and odd-syndrome accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            a1_q   <= '0;
            a3_q   <= '0;
            a5_q   <= '0;
        end else if (accept) begin
            word_q <= W'(received);
            cnt_q  <= CNT_LAST;
            a1_q   <= '0;
            a3_q   <= '0;
            a5_q   <= '0;
        end else if (state_q == StBusy) begin
            a1_q <= a1_d;
            a3_q <= a3_d;
            a5_q <= a5_d;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Even syndromes follow from S1 by squaring: S2 = S1^2, S4 = S2^2.
    always_comb begin
        a1_sq        = gf_square(a1_q);
        syndrome1    = a1_q;
        syndrome2    = a1_sq;
        syndrome3    = a3_q;
        syndrome4    = gf_square(a1_sq);
        syndrome5    = a5_q;
        received_out = word_q[N-1:0];
        no_error     = out_valid && (a1_q == '0) && (a3_q == '0) && (a5_q == '0);
    end

endmodule

// File: tb/tb_bch_syndrome_seq.sv
// Self-checking bench: random and directed words against an r(alpha^j) evaluation model.
module tb_bch_syndrome_seq;

    localparam int N      = 542;
    localparam int NCHUNK = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] received = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] received_out;
    logic [9:0]   syndrome1, syndrome2, syndrome3, syndrome4, syndrome5;
    logic         no_error;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_t [0:1022];
    logic [9:0] gp [0:30];
    logic [N-1:0] gv;

    bch_syndrome_seq #(.CHUNK(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .received(received), .out_valid(out_valid), .out_ready(out_ready),
        .received_out(received_out), .syndrome1(syndrome1), .syndrome2(syndrome2),
        .syndrome3(syndrome3), .syndrome4(syndrome4), .syndrome5(syndrome5),
        .no_error(no_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [9:0] xtime(input logic [9:0] a);
        return {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
    endfunction

    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p = '0;
        logic [9:0] x = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // r(alpha^j): sum of alpha^(j*i) over the set bits i of the word.
    function automatic logic [9:0] model_syn(input logic [N-1:0] r, input int j);
        logic [9:0] s = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) s = s ^ exp_t[(j * i) % 1023];
        end
        return s;
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [543:0] t;
        for (int k = 0; k < 17; k++) t[k*32 +: 32] = $urandom;
        return t[N-1:0];
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_syn(input string tag, input logic [9:0] s [1:5]);
        check({tag, " S1"}, N'(syndrome1), N'(s[1]));
        check({tag, " S2"}, N'(syndrome2), N'(s[2]));
        check({tag, " S3"}, N'(syndrome3), N'(s[3]));
        check({tag, " S4"}, N'(syndrome4), N'(s[4]));
        check({tag, " S5"}, N'(syndrome5), N'(s[5]));
    endtask

    task automatic check_reset_vals(input string tag);
        logic [9:0] z [1:5];
        for (int j = 1; j <= 5; j++) z[j] = '0;
        check({tag, " in_ready"}, N'(in_ready), N'(1'b1));
        check({tag, " out_valid"}, N'(out_valid), N'(1'b0));
        check({tag, " no_error"}, N'(no_error), N'(1'b0));
        check({tag, " received_out"}, received_out, '0);
        check_syn(tag, z);
    endtask

    // Push one word, wait for the result, optionally stall with a competing
    // in_valid for `hold` cycles, then release.
    task automatic run_word(input logic [N-1:0] w, input int hold, input string tag);
        logic [9:0] s [1:5];
        logic       ne;
        int         cyc;
        for (int j = 1; j <= 5; j++) s[j] = model_syn(w, j);
        ne = (s[1] == 0) && (s[3] == 0) && (s[5] == 0);
        @(negedge clk);
        check({tag, " in_ready_idle"}, N'(in_ready), N'(1'b1));
        received = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 4 * NCHUNK) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, N'(cyc), N'(NCHUNK));
        check_syn(tag, s);
        check({tag, " no_error"}, N'(no_error), N'(ne));
        check({tag, " received_out"}, received_out, w);
        check({tag, " in_ready_done"}, N'(in_ready), N'(1'b0));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            received = ~w;
            @(posedge clk);
            #1;
            check({tag, " hold out_valid"}, N'(out_valid), N'(1'b1));
            check({tag, " hold in_ready"}, N'(in_ready), N'(1'b0));
            check({tag, " hold received_out"}, received_out, w);
            check_syn({tag, " hold"}, s);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " released out_valid"}, N'(out_valid), N'(1'b0));
        check({tag, " released in_ready"}, N'(in_ready), N'(1'b1));
        check({tag, " released received_out"}, received_out, w);
    endtask

    initial begin
        logic [N-1:0] w, c;
        logic [511:0] msg;
        logic [9:0]   beta, z [1:5];
        int           deg, e;

        // GF(2^10) antilog table from x^10 = x^3 + 1.
        exp_t[0] = 10'h001;
        for (int i = 1; i < 1023; i++) exp_t[i] = xtime(exp_t[i-1]);

        // Generator polynomial: product of (x + beta) over the conjugates of alpha, alpha^3, alpha^5.
        for (int i = 0; i <= 30; i++) gp[i] = '0;
        gp[0] = 10'h001;
        deg = 0;
        for (int j = 1; j <= 5; j += 2) begin
            e = j;
            for (int k = 0; k < 10; k++) begin
                beta = exp_t[e];
                for (int i = deg + 1; i >= 1; i--) gp[i] = gp[i-1] ^ gmul(beta, gp[i]);
                gp[0] = gmul(beta, gp[0]);
                deg++;
                e = (e * 2) % 1023;
            end
        end
        gv = '0;
        for (int i = 0; i <= 30; i++) gv[i] = gp[i][0];

        #12;
        check_reset_vals("reset");
        rst_n = 1'b1;
        #3;
        check_reset_vals("after_reset");

        run_word('0, 0, "zero");
        check("zero no_error_kept_low", N'(no_error), N'(1'b0));

        w = '0; w[0] = 1'b1;
        run_word(w, 0, "bit0");
        for (int j = 1; j <= 5; j++) z[j] = 10'h001;
        check_syn("bit0 const", z);

        w = '0; w[1] = 1'b1;
        run_word(w, 0, "bit1");
        z[1] = 10'h002; z[2] = 10'h004; z[3] = 10'h008; z[4] = 10'h010; z[5] = 10'h020;
        check_syn("bit1 const", z);

        // Codeword = random message polynomial times generator.
        for (int k = 0; k < 16; k++) msg[k*32 +: 32] = $urandom;
        c = '0;
        for (int k = 0; k < 512; k++) if (msg[k]) c = c ^ (gv << k);
        run_word(c, 0, "clean");
        for (int j = 1; j <= 5; j++) z[j] = '0;
        check_syn("clean zero", z);

        w = c; w[541] = ~w[541];
        run_word(w, 0, "err1_b541");
        w = c; w[63] = ~w[63]; w[64] = ~w[64];
        run_word(w, 0, "err2_b63_64");
        w = c;
        w[$urandom_range(0, 179)]   ^= 1'b1;
        w[$urandom_range(180, 359)] ^= 1'b1;
        w[$urandom_range(360, 541)] ^= 1'b1;
        run_word(w, 0, "err3_rand");

        run_word(rand_word(), 5, "hold");
        run_word(rand_word(), 0, "random");

        // Reset while BUSY with cnt = 4, then confirm normal operation resumes.
        w = rand_word();
        @(negedge clk);
        received = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midbusy_reset");
        #2;
        rst_n = 1'b1;
        repeat (NCHUNK + 2) begin
            @(posedge clk);
            #1;
            check("post_reset no_out_valid", N'(out_valid), N'(1'b0));
        end
        run_word(w, 0, "after_midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
